shift_dispatch: RTL

Decode-and-issue stage sitting directly upstream of the 32-bit barrel shifter (`shifter32`) in the execute path. It accepts RV32I shift instructions (SLL/SRL/SRA, SLLI/SRLI/SRAI) with operands and destination tag over a valid/ready handshake. It decodes them into the shifter's `a`/`shamt`/`mode` inputs and holds them in a registered pipeline stage so the shifter always sees stable, registered operands. It also flags illegal encodings and counts issued operations.

---
 rtl/shift_pkg.sv | 21 ++
 rtl/shift_skid_buf.sv | 96 +++++++++
 rtl/shift_dispatch.sv | 95 +++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types and decode constants for the shift issue stage
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10
    } shift_mode_e;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    typedef struct packed {
        logic [31:0] a;
        logic [4:0]  shamt;
        shift_mode_e mode;
        logic [4:0]  rd;
        logic        illegal;
    } shift_req_t;

endpackage

// File: rtl/shift_skid_buf.sv
// rtl/shift_skid_buf.sv - valid/ready register stage over shift_req_t
// Ports:
//   i_clk, i_rst_n                   clock, asynchronous active-low reset
//   i_s_tvalid/o_s_tready/i_s_tdata  upstream request stream
//   o_m_tvalid/i_m_tready/o_m_tdata  downstream (registered) stream
// Build option SHIFT_DISPATCH_SKID_EN: adds a skid entry so o_s_tready is a
// flop output; otherwise a single stage with combinational ready.
module shift_skid_buf
    import shift_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_s_tvalid,
    output logic       o_s_tready,
    input  shift_req_t i_s_tdata,
    output logic       o_m_tvalid,
    input  logic       i_m_tready,
    output shift_req_t o_m_tdata
);

    logic       main_v_q, main_v_d;
    shift_req_t main_q, main_d;
    logic       out_fire;

    assign out_fire   = main_v_q & i_m_tready;
    assign o_m_tvalid = main_v_q;
    assign o_m_tdata  = main_q;

`ifdef SHIFT_DISPATCH_SKID_EN
    logic       skid_v_q, skid_v_d;
    shift_req_t skid_q, skid_d;
    logic       in_fire;

    // Ready only depends on skid occupancy, so no i_m_tready -> o_s_tready path.
    assign o_s_tready = ~skid_v_q;
    assign in_fire    = i_s_tvalid & ~skid_v_q;

    always_comb begin
        main_v_d = main_v_q;
        main_d   = main_q;
        skid_v_d = skid_v_q;
        skid_d   = skid_q;
        if (!main_v_q || out_fire) begin
            if (skid_v_q) begin
                // Older skid entry goes first; input is blocked while skid is full.
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = 1'b0;
            end else begin
                main_v_d = in_fire;
                if (in_fire) begin
                    main_d = i_s_tdata;
                end
            end
        end else if (in_fire) begin
            // Main is stalled: park the new request in the skid entry.
            skid_d   = i_s_tdata;
            skid_v_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            skid_v_q <= 1'b0;
            skid_q   <= '0;
        end else begin
            skid_v_q <= skid_v_d;
            skid_q   <= skid_d;
        end
    end
`else
    assign o_s_tready = ~main_v_q | i_m_tready;

    always_comb begin
        main_v_d = main_v_q;
        main_d   = main_q;
        if (o_s_tready) begin
            main_v_d = i_s_tvalid;
            if (i_s_tvalid) begin
                main_d = i_s_tdata;
            end
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_v_q <= 1'b0;
            main_q   <= '0;
        end else begin
            main_v_q <= main_v_d;
            main_q   <= main_d;
        end
    end

endmodule

// File: rtl/shift_dispatch.sv
// rtl/shift_dispatch.sv - decode-and-issue stage feeding the 32-bit barrel shifter
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_valid/o_ready                request handshake
//   i_funct3, i_funct7_5, i_is_imm instruction decode fields
//   i_rs1, i_rs2, i_imm_shamt      operand, register and immediate shift amounts
//   i_rd                           destination tag
//   o_valid/i_ready                issue handshake
//   o_a, o_shamt, o_mode, o_rd     registered shifter inputs and tag
//   o_illegal                      encoding was not a legal shift
//   o_issued_cnt                   count of issue handshakes (wraps)
// Build option SHIFT_DISPATCH_SKID_EN selects the skid-buffered stage.
module shift_dispatch
    import shift_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_funct3,
    input  logic             i_funct7_5,
    input  logic             i_is_imm,
    input  logic [31:0]      i_rs1,
    input  logic [31:0]      i_rs2,
    input  logic [4:0]       i_imm_shamt,
    input  logic [4:0]       i_rd,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_a,
    output logic [4:0]       o_shamt,
    output logic [1:0]       o_mode,
    output logic [4:0]       o_rd,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_issued_cnt
);

    shift_req_t       req_d;
    shift_req_t       out_req;
    logic [4:0]       shamt_src;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             unused_rs2_hi;

    // Only rs2[4:0] can change the shift amount.
    assign unused_rs2_hi = ^i_rs2[31:5];
    assign shamt_src     = i_is_imm ? i_imm_shamt : i_rs2[4:0];

    always_comb begin
        req_d         = '0;
        req_d.a       = i_rs1;
        req_d.rd      = i_rd;
        req_d.mode    = SHIFT_SLL;
        req_d.illegal = 1'b0;
        if (i_funct3 == F3_SLL && !i_funct7_5) begin
            req_d.shamt = shamt_src;
        end else if (i_funct3 == F3_SRX) begin
            req_d.shamt = shamt_src;
            req_d.mode  = i_funct7_5 ? SHIFT_SRA : SHIFT_SRL;
        end else begin
            // Still issued so the tag retires; shamt/mode forced to a benign SLL by 0.
            req_d.illegal = 1'b1;
        end
    end

    shift_skid_buf u_buf (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_s_tvalid (i_valid),
        .o_s_tready (o_ready),
        .i_s_tdata  (req_d),
        .o_m_tvalid (o_valid),
        .i_m_tready (i_ready),
        .o_m_tdata  (out_req)
    );

    assign o_a       = out_req.a;
    assign o_shamt   = out_req.shamt;
    assign o_mode    = out_req.mode;
    assign o_rd      = out_req.rd;
    assign o_illegal = out_req.illegal;

    assign cnt_d = cnt_q + CNT_W'(o_valid & i_ready);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_issued_cnt = cnt_q;

endmodule
